line_buffer_sync: RTL and testbench
===================================

# line_buffer_sync

Start-up and resynchronisation controller for the shared line-buffer RAM between the capture-side line writer and the `ram2video` reader. It counts lines written versus lines consumed and fires the reader's `starttrigger` once enough lines are buffered. It detects underrun and overrun, and forces a controlled reader reset and refill on any error or mode change.

## Interface
Parameters:
- `BUFFER_LINES`, 16: ring depth in buffer lines (1..255).
- `START_LINES`, 8: lines buffered before start (1..`BUFFER_LINES`).
- `LOCK_FRAMES`, 4: error-free input frames in RUN before `locked` asserts (1..255).
- `RESYNC_CYCLES`, 4: cycles `video_reset_n` is held low (1..255).
- `ARM_TIMEOUT`, 16: cycles to wait for `rd_restart` after the trigger (1..255).

Ports:
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: asynchronous, active-low.
- `wr_frame_start`, in, 1: one-cycle pulse at input vsync.
- `wr_line_done`, in, 1: one-cycle pulse when the writer completes one buffer line.
- `rd_line_adv`, in, 1: one-cycle pulse when the reader releases one buffer line.
- `rd_restart`, in, 1: `restart` from `ram2video`.
- `mode_change`, in, 1: pulse on a `line_doubler`/`add_line` change.
- `clear_errors`, in, 1: pulse that clears the sticky flags and `error_count`.
- `starttrigger`, out, 1: one-cycle start pulse to the reader.
- `video_reset_n`, out, 1: active-low reset to the reader.
- `fill`, out, 8: current buffered-line count.
- `locked`, out, 1: stable operation.
- `underrun`, out, 1: sticky flag.
- `overrun`, out, 1: sticky flag.
- `error_count`, out, 8: saturating count of resyncs caused by an error.
- `state`, out, 3: encoding RESYNC=0, WAIT_FRAME=1, FILL=2, ARMED=3, RUN=4.

## Operation
- States: RESYNC, WAIT_FRAME, FILL, ARMED, RUN. Reset enters RESYNC with `rs_cnt`=`RESYNC_CYCLES`.
- **RESYNC**
  - `video_reset_n`=0, `fill`=0, `locked`=0, `rs_cnt` decrements each cycle.
  - When `rs_cnt`==1, the next state is WAIT_FRAME.
- **WAIT_FRAME**
  - `wr_line_done` and `rd_line_adv` are ignored.
  - On `wr_frame_start` go to FILL. `fill` becomes 1 if `wr_line_done` is in the same cycle, else 0.
- **FILL**
  - `wr_line_done` increments `fill`.
  - A repeated `wr_frame_start` reloads `fill` to 0, or 1 with a simultaneous line.
  - When the incremented `fill` equals `START_LINES`, go to ARMED.
- **ARMED**
  - `starttrigger`=1 only in the first ARMED cycle.
  - `wr_line_done` still increments `fill`, saturating at `BUFFER_LINES` with no error.
  - `rd_restart`=1 in any ARMED cycle goes to RUN.
  - If `ARM_TIMEOUT` cycles pass without `rd_restart`, go to RESYNC and count an error.
- **RUN**
  - `fill` += `wr_line_done`, −= `rd_line_adv`. Simultaneous pulses leave it unchanged with no error.
  - `rd_line_adv` alone with `fill`==0: set `underrun`, go to RESYNC, count an error.
  - `wr_line_done` alone with `fill`==`BUFFER_LINES`: set `overrun`, go to RESYNC, count an error.
  - `wr_frame_start` increments `frames_ok`, saturating at 255. `locked`=1 while `frames_ok`≥`LOCK_FRAMES`.
- **From any state:** `mode_change` goes to RESYNC without counting an error and has priority over all other events. It reloads `rs_cnt` even if already in RESYNC.
- **Error counting:** an error-caused resync increments `error_count`, saturating at 255.
- **`clear_errors`:** clears `underrun`, `overrun` and `error_count`. If it coincides with a new error, the new error wins: flag set, count=1.
- **Leaving RUN:** clears `frames_ok` and `locked`.

## Timing
- All outputs are registered; decisions take effect on the next `clock` edge.
- Reset values: `starttrigger`=0, `video_reset_n`=0, `fill`=0, `locked`=0, `underrun`=0, `overrun`=0, `error_count`=0, `state`=0.
- Reset release to `video_reset_n`=1: `RESYNC_CYCLES` cycles.
- Completing line `START_LINES` (pulse at edge N) gives `starttrigger`=1 in cycle N+1.
- A `rd_restart` sampled at edge M gives `state`=RUN after edge M.
- Error detected at edge E: flag and `state`=RESYNC after E; `video_reset_n`=0 from E+1 for `RESYNC_CYCLES` cycles.
- An asynchronous reset mid-operation clears everything immediately, including the sticky flags.

## Test plan
- **Start-up:** reset, release, frame pulse, 8 line pulses 3 cycles apart → `video_reset_n` rises 4 cycles after release; `starttrigger` is one cycle wide, one cycle after the 8th line; `fill`=8.
- **Steady run:** `rd_restart` then balanced write/read including simultaneous pulses, 5 frame pulses → `fill` constant at 8, `locked`=1 after the 4th frame, no flags.
- **Underrun:** in RUN drain to `fill`=0, then one `rd_line_adv` → `underrun`=1, `error_count`=1, `state`=RESYNC, `video_reset_n` low 4 cycles, then `state`=WAIT_FRAME.
- **Overrun:** fill to 16, then one `wr_line_done` alone → `overrun`=1, `error_count` increments, `fill` resets to 0.
- **Arm timeout:** reach ARMED with no `rd_restart` for 16 cycles → RESYNC, `error_count`+1; `clear_errors` coinciding with a later error leaves `error_count`=1.
- **Mode change:** `mode_change` in RUN and again mid-RESYNC → `error_count` unchanged, `locked`=0, `rs_cnt` reloaded (RESYNC lasts 4 cycles from the last pulse).

Source files
------------

// File: rtl/line_buffer_sync.sv
// Start-up / resync controller for the shared line-buffer RAM: tracks buffered lines,
// triggers the reader once primed, and forces a reader reset + refill on errors or mode changes.
module line_buffer_sync #(
    parameter int BUFFER_LINES  = 16,
    parameter int START_LINES   = 8,
    parameter int LOCK_FRAMES   = 4,
    parameter int RESYNC_CYCLES = 4,
    parameter int ARM_TIMEOUT   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_frame_start,
    input  logic       wr_line_done,
    input  logic       rd_line_adv,
    input  logic       rd_restart,
    input  logic       mode_change,
    input  logic       clear_errors,
    output logic       starttrigger,
    output logic       video_reset_n,
    output logic [7:0] fill,
    output logic       locked,
    output logic       underrun,
    output logic       overrun,
    output logic [7:0] error_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        RESYNC     = 3'd0,
        WAIT_FRAME = 3'd1,
        FILL       = 3'd2,
        ARMED      = 3'd3,
        RUN        = 3'd4
    } state_t;

    localparam logic [7:0] BUF_L  = 8'(BUFFER_LINES);
    localparam logic [7:0] START_L = 8'(START_LINES);
    localparam logic [7:0] LOCK_F = 8'(LOCK_FRAMES);
    localparam logic [7:0] RS_C   = 8'(RESYNC_CYCLES);
    localparam logic [7:0] ARM_T  = 8'(ARM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] rs_cnt_q, rs_cnt_d;
    logic [7:0] arm_cnt_q, arm_cnt_d;
    logic [7:0] frames_q, frames_d;
    logic [7:0] fill_d, err_cnt_d;
    logic       trig_d, under_d, over_d, locked_d;
    logic       err_evt, under_set, over_set;

    assign state = state_q;

    always_comb begin
        state_d   = state_q;
        rs_cnt_d  = rs_cnt_q;
        arm_cnt_d = arm_cnt_q;
        frames_d  = frames_q;
        fill_d    = fill;
        trig_d    = 1'b0;
        err_evt   = 1'b0;
        under_set = 1'b0;
        over_set  = 1'b0;

        case (state_q)
            RESYNC: begin
                rs_cnt_d = rs_cnt_q - 8'd1;
                if (rs_cnt_q <= 8'd1) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (wr_frame_start) begin
                    fill_d  = {7'd0, wr_line_done};
                    state_d = FILL;
                    if (wr_line_done && fill_d == START_L) begin
                        state_d   = ARMED;
                        trig_d    = 1'b1;
                        arm_cnt_d = 8'd0;
                    end
                end
            end
            FILL: begin
                // a repeated frame start restarts priming from this frame's first line
                fill_d = (wr_frame_start ? 8'd0 : fill) + {7'd0, wr_line_done};
                if (wr_line_done && fill_d == START_L) begin
                    state_d   = ARMED;
                    trig_d    = 1'b1;
                    arm_cnt_d = 8'd0;
                end
            end
            ARMED: begin
                if (wr_line_done && fill != BUF_L) fill_d = fill + 8'd1;
                if (rd_restart) begin
                    state_d  = RUN;
                    frames_d = 8'd0;
                end else if (arm_cnt_q >= ARM_T - 8'd1) begin
                    state_d = RESYNC;
                    err_evt = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (wr_frame_start && frames_q != 8'hFF) frames_d = frames_q + 8'd1;
                if (wr_line_done && !rd_line_adv) begin
                    if (fill == BUF_L) begin
                        over_set = 1'b1;
                        err_evt  = 1'b1;
                        state_d  = RESYNC;
                    end else begin
                        fill_d = fill + 8'd1;
                    end
                end else if (rd_line_adv && !wr_line_done) begin
                    if (fill == 8'd0) begin
                        under_set = 1'b1;
                        err_evt   = 1'b1;
                        state_d   = RESYNC;
                    end else begin
                        fill_d = fill - 8'd1;
                    end
                end
            end
            default: state_d = RESYNC;
        endcase

        // mode change overrides every other event and never counts as an error
        if (mode_change) begin
            state_d   = RESYNC;
            err_evt   = 1'b0;
            under_set = 1'b0;
            over_set  = 1'b0;
            trig_d    = 1'b0;
        end

        if (state_d == RESYNC) begin
            fill_d = 8'd0;
            if (state_q != RESYNC || mode_change) rs_cnt_d = RS_C;
        end
        if (state_d != RUN) frames_d = 8'd0;

        // a new error in the same cycle as a clear survives the clear
        under_d   = (clear_errors ? 1'b0 : underrun) | under_set;
        over_d    = (clear_errors ? 1'b0 : overrun) | over_set;
        err_cnt_d = clear_errors ? 8'd0 : error_count;
        if (err_evt) begin
            if (clear_errors)              err_cnt_d = 8'd1;
            else if (error_count != 8'hFF) err_cnt_d = error_count + 8'd1;
        end

        locked_d = (state_d == RUN) && (frames_d >= LOCK_F);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RESYNC;
            rs_cnt_q      <= RS_C;
            arm_cnt_q     <= 8'd0;
            frames_q      <= 8'd0;
            fill          <= 8'd0;
            starttrigger  <= 1'b0;
            video_reset_n <= 1'b0;
            locked        <= 1'b0;
            underrun      <= 1'b0;
            overrun       <= 1'b0;
            error_count   <= 8'd0;
        end else begin
            state_q       <= state_d;
            rs_cnt_q      <= rs_cnt_d;
            arm_cnt_q     <= arm_cnt_d;
            frames_q      <= frames_d;
            fill          <= fill_d;
            starttrigger  <= trig_d;
            video_reset_n <= (state_d != RESYNC);
            locked        <= locked_d;
            underrun      <= under_d;
            overrun       <= over_d;
            error_count   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_sync.sv
// Directed bench for line_buffer_sync: table of per-cycle vectors for start-up/run/underrun,
// then hand sequences for overrun, arm timeout, clear/error collision, mode change and async reset.
module tb_line_buffer_sync;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_frame_start = 1'b0, wr_line_done = 1'b0, rd_line_adv = 1'b0;
    logic       rd_restart = 1'b0, mode_change = 1'b0, clear_errors = 1'b0;
    logic       starttrigger, video_reset_n, locked, underrun, overrun;
    logic [7:0] fill, error_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // pulse encoding {frame, line, adv, restart, mode, clear}
    localparam logic [5:0] N = 6'b000000, F = 6'b100000, L = 6'b010000, A = 6'b001000;
    localparam logic [5:0] R = 6'b000100, M = 6'b000010, C = 6'b000001;

    typedef struct {
        logic [5:0] in;
        int st, fl, trig, vrn, lock, un, ov, ec;
    } vec_t;
    vec_t tbl[$];

    line_buffer_sync dut (
        .clock(clock), .reset(reset),
        .wr_frame_start(wr_frame_start), .wr_line_done(wr_line_done),
        .rd_line_adv(rd_line_adv), .rd_restart(rd_restart),
        .mode_change(mode_change), .clear_errors(clear_errors),
        .starttrigger(starttrigger), .video_reset_n(video_reset_n),
        .fill(fill), .locked(locked), .underrun(underrun), .overrun(overrun),
        .error_count(error_count), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] p);
        {wr_frame_start, wr_line_done, rd_line_adv, rd_restart, mode_change, clear_errors} = p;
        @(posedge clock);
        #1;
        {wr_frame_start, wr_line_done, rd_line_adv, rd_restart, mode_change, clear_errors} = N;
    endtask

    task automatic add(input logic [5:0] in, input int st, input int fl, input int trig,
                       input int vrn, input int lock, input int un, input int ov, input int ec);
        vec_t v;
        v.in = in; v.st = st; v.fl = fl; v.trig = trig; v.vrn = vrn;
        v.lock = lock; v.un = un; v.ov = ov; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic fill_to_armed(input string tag);
        cyc(F);
        chk({tag, " fill-entry state"}, int'(state), 2);
        for (int k = 1; k <= 8; k++) cyc(L);
        chk({tag, " armed state"}, int'(state), 3);
        chk({tag, " armed fill"}, int'(fill), 8);
        chk({tag, " trigger"}, int'(starttrigger), 1);
    endtask

    initial begin
        // start-up: RESYNC for 4 edges after release, WAIT ignores lines, 8 lines 3 apart
        add(N, 0, 0, 0, 0, 0, 0, 0, 0);
        add(N, 0, 0, 0, 0, 0, 0, 0, 0);
        add(N, 0, 0, 0, 0, 0, 0, 0, 0);
        add(N, 1, 0, 0, 1, 0, 0, 0, 0);
        add(L, 1, 0, 0, 1, 0, 0, 0, 0);
        add(F, 2, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            add(L, (k == 8) ? 3 : 2, k, (k == 8) ? 1 : 0, 1, 0, 0, 0, 0);
            if (k < 8) begin
                add(N, 2, k, 0, 1, 0, 0, 0, 0);
                add(N, 2, k, 0, 1, 0, 0, 0, 0);
            end
        end
        add(N, 3, 8, 0, 1, 0, 0, 0, 0);
        // steady run, balanced traffic, 5 frames
        add(R,         4, 8, 0, 1, 0, 0, 0, 0);
        add(F,         4, 8, 0, 1, 0, 0, 0, 0);
        add(L,         4, 9, 0, 1, 0, 0, 0, 0);
        add(A,         4, 8, 0, 1, 0, 0, 0, 0);
        add(F | L | A, 4, 8, 0, 1, 0, 0, 0, 0);
        add(L | A,     4, 8, 0, 1, 0, 0, 0, 0);
        add(F,         4, 8, 0, 1, 0, 0, 0, 0);
        add(F | L,     4, 9, 0, 1, 1, 0, 0, 0);
        add(A,         4, 8, 0, 1, 1, 0, 0, 0);
        add(F | L | A, 4, 8, 0, 1, 1, 0, 0, 0);
        // drain then underrun
        for (int k = 7; k >= 0; k--) add(A, 4, k, 0, 1, 1, 0, 0, 0);
        add(A, 0, 0, 0, 0, 0, 1, 0, 1);
        add(N, 0, 0, 0, 0, 0, 1, 0, 1);
        add(N, 0, 0, 0, 0, 0, 1, 0, 1);
        add(N, 0, 0, 0, 0, 0, 1, 0, 1);
        add(N, 1, 0, 0, 1, 0, 1, 0, 1);

        repeat (2) @(posedge clock);
        #1;
        chk("reset state", int'(state), 0);
        chk("reset vrn", int'(video_reset_n), 0);
        chk("reset fill", int'(fill), 0);
        chk("reset trig", int'(starttrigger), 0);
        chk("reset ec", int'(error_count), 0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].in);
            chk($sformatf("vec%0d state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d fill", i), int'(fill), tbl[i].fl);
            chk($sformatf("vec%0d trig", i), int'(starttrigger), tbl[i].trig);
            chk($sformatf("vec%0d vrn", i), int'(video_reset_n), tbl[i].vrn);
            chk($sformatf("vec%0d locked", i), int'(locked), tbl[i].lock);
            chk($sformatf("vec%0d underrun", i), int'(underrun), tbl[i].un);
            chk($sformatf("vec%0d overrun", i), int'(overrun), tbl[i].ov);
            chk($sformatf("vec%0d ec", i), int'(error_count), tbl[i].ec);
        end

        // overrun: restart with a line, fill to 16, one more lone line
        fill_to_armed("ovr");
        cyc(R | L);
        chk("ovr run state", int'(state), 4);
        chk("ovr run fill", int'(fill), 9);
        repeat (7) cyc(L);
        chk("ovr full fill", int'(fill), 16);
        cyc(L);
        chk("ovr state", int'(state), 0);
        chk("ovr flag", int'(overrun), 1);
        chk("ovr underrun sticky", int'(underrun), 1);
        chk("ovr ec", int'(error_count), 2);
        chk("ovr fill", int'(fill), 0);
        repeat (4) cyc(N);
        chk("ovr wait", int'(state), 1);

        // arm timeout with fill saturating at 16 inside ARMED
        fill_to_armed("to1");
        repeat (10) cyc(L);
        chk("to1 sat fill", int'(fill), 16);
        chk("to1 still armed", int'(state), 3);
        chk("to1 trig low", int'(starttrigger), 0);
        repeat (5) cyc(N);
        chk("to1 last armed", int'(state), 3);
        cyc(N);
        chk("to1 state", int'(state), 0);
        chk("to1 ec", int'(error_count), 3);
        repeat (4) cyc(N);

        // timeout coinciding with clear_errors
        fill_to_armed("to2");
        repeat (15) cyc(N);
        chk("to2 last armed", int'(state), 3);
        cyc(C);
        chk("to2 state", int'(state), 0);
        chk("to2 ec", int'(error_count), 1);
        chk("to2 underrun clr", int'(underrun), 0);
        chk("to2 overrun clr", int'(overrun), 0);
        repeat (4) cyc(N);
        chk("to2 wait", int'(state), 1);

        // mode change in RUN, then again mid-RESYNC
        fill_to_armed("mc");
        cyc(R);
        repeat (4) cyc(F);
        chk("mc locked", int'(locked), 1);
        cyc(M);
        chk("mc state", int'(state), 0);
        chk("mc locked clr", int'(locked), 0);
        chk("mc vrn", int'(video_reset_n), 0);
        chk("mc ec", int'(error_count), 1);
        repeat (2) cyc(N);
        cyc(M);
        repeat (3) cyc(N);
        chk("mc reload state", int'(state), 0);
        chk("mc reload vrn", int'(video_reset_n), 0);
        cyc(N);
        chk("mc exit state", int'(state), 1);
        chk("mc exit ec", int'(error_count), 1);

        // asynchronous reset mid-operation
        cyc(F);
        #3;
        reset = 1'b0;
        #1;
        chk("areset state", int'(state), 0);
        chk("areset ec", int'(error_count), 0);
        chk("areset vrn", int'(video_reset_n), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
